prio_event_encoder: RTL

// - Parametrised, registered successor to the 8-input combinational priority encoder.
// - Captures N request lines into a sticky pending register and applies a per-line mask.
// - Presents one winning index at a time on a valid/ready handshake, in fixed or round-robin priority.
// - Sits between raw event/interrupt sources and a single consumer (controller, CPU interface).

---
 rtl/prio_enc_pkg.sv | 17 +
 rtl/prio_pick.sv | 36 +++
 rtl/prio_event_encoder.sv | 96 +++++++++
 3 files changed

// File: rtl/prio_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc_pkg
// Brief    : Shared mode constants and index-width helper for the encoder.
// Revision : 1.0
// ============================================================================
package prio_enc_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prio_pick.sv
`default_nettype none
// ============================================================================
// Module   : prio_pick
// Brief    : First set bit of vec at or after start, wrapping modulo N.
// Revision : 1.0
// ============================================================================
module prio_pick
    import prio_enc_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     vec,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] w_pos;

    // start is expected in 0..N-1; the wrap compare keeps non-power-of-2 N correct
    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_pos = start;
        for (int k = 0; k < N; k++) begin
            if (!found && vec[w_pos]) begin
                found = 1'b1;
                idx   = w_pos;
            end
            w_pos = (w_pos == IDX_W'(N - 1)) ? '0 : w_pos + IDX_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/prio_event_encoder.sv
`default_nettype none
// ============================================================================
// Module   : prio_event_encoder
// Brief    : Sticky, maskable request capture with registered valid/ready
//            grant output in fixed or round-robin priority.
// Revision : 1.0
// ============================================================================
module prio_event_encoder
    import prio_enc_pkg::*;
#(
    parameter int N       = 8,
    parameter int IDX_W   = idx_width(N),
    parameter int RR_MODE = MODE_FIXED,
    parameter int EDGE    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     pending,
    output logic             any_pending
);

    logic [N-1:0]     r_req_d;
    logic [N-1:0]     r_pending;
    logic [IDX_W-1:0] r_rr_ptr;
    logic             r_out_valid;
    logic [IDX_W-1:0] r_out_idx;

    logic             w_fire;
    logic [N-1:0]     w_set;
    logic [N-1:0]     w_clear;
    logic [N-1:0]     w_cand;
    logic [IDX_W-1:0] w_start;
    logic             w_found;
    logic [IDX_W-1:0] w_pick;

    assign w_fire = r_out_valid & out_ready;
    assign w_set  = (EDGE != 0) ? (req & ~r_req_d) : req;

    always_comb begin
        w_clear = '0;
        for (int i = 0; i < N; i++) begin
            w_clear[i] = w_fire && (r_out_idx == IDX_W'(i));
        end
    end

    // The line being granted this cycle is not re-offered until its
    // re-request has landed in pending, one cycle later.
    assign w_cand  = r_pending & ~mask & ~w_clear;
    assign w_start = ((RR_MODE == MODE_RR) && (r_rr_ptr != IDX_W'(N - 1)))
                     ? r_rr_ptr + IDX_W'(1) : '0;

    prio_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .vec   (w_cand),
        .start (w_start),
        .found (w_found),
        .idx   (w_pick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_d     <= '0;
            r_pending   <= '0;
            r_rr_ptr    <= IDX_W'(N - 1);
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
        end else begin
            r_req_d   <= req;
            r_pending <= (r_pending & ~w_clear) | w_set;
            if (w_fire) begin
                r_rr_ptr <= r_out_idx;
            end
            // Presented index is frozen while the consumer stalls
            if (!r_out_valid || w_fire) begin
                r_out_valid <= w_found;
                if (w_found) begin
                    r_out_idx <= w_pick;
                end
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_idx     = r_out_idx;
    assign pending     = r_pending;
    assign any_pending = |r_pending;

endmodule
`default_nettype wire
